// File: rtl/sram_controller.sv
// Single-port asynchronous SRAM controller with a ready/strobe client handshake.
// Generates registered ce_n/oe_n/we_n timing and holds the last read word for the client.
module sram_controller #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2   // oe_n / we_n active width in clk cycles, 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_write,
    input  logic              read,
    input  logic              write,
    output logic              ready,
    output logic [DATA_W-1:0] data_read,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_out,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic              sram_data_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    output logic [2:0]        state_dbg
);

    // Handshake: ready=1 means idle; a request is taken on a clk edge where
    // ready=1 and read|write=1 (read wins when both are set). Strobes seen while
    // ready=0 are dropped, never queued. ready returns to 1 when the access ends.

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_ACCESS = 3'd1,
        S_WR_SETUP  = 3'd2,
        S_WR_PULSE  = 3'd3,
        S_WR_HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_read_q, data_read_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_data_out_q, sram_data_out_d;
    logic              data_oe_q, data_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= 4'd0;
            ready_q         <= 1'b0;
            data_read_q     <= '0;
            sram_addr_q     <= '0;
            sram_data_out_q <= '0;
            data_oe_q       <= 1'b0;
            ce_n_q          <= 1'b1;
            oe_n_q          <= 1'b1;
            we_n_q          <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ready_q         <= ready_d;
            data_read_q     <= data_read_d;
            sram_addr_q     <= sram_addr_d;
            sram_data_out_q <= sram_data_out_d;
            data_oe_q       <= data_oe_d;
            ce_n_q          <= ce_n_d;
            oe_n_q          <= oe_n_d;
            we_n_q          <= we_n_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ready_d         = ready_q;
        data_read_d     = data_read_q;
        sram_addr_d     = sram_addr_q;
        sram_data_out_d = sram_data_out_q;
        data_oe_d       = data_oe_q;
        ce_n_d          = ce_n_q;
        oe_n_d          = oe_n_q;
        we_n_d          = we_n_q;

        case (state_q)
            S_IDLE: begin
                // ready_q is 0 only on the first cycle after reset release
                ready_d = 1'b1;
                if (ready_q && read) begin
                    ready_d     = 1'b0;
                    sram_addr_d = address;
                    ce_n_d      = 1'b0;
                    oe_n_d      = 1'b0;
                    cnt_d       = 4'd0;
                    state_d     = S_RD_ACCESS;
                end else if (ready_q && write) begin
                    ready_d         = 1'b0;
                    sram_addr_d     = address;
                    sram_data_out_d = data_write;
                    ce_n_d          = 1'b0;
                    data_oe_d       = 1'b1;
                    state_d         = S_WR_SETUP;
                end
            end

            S_RD_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    data_read_d = sram_data_in;
                    oe_n_d      = 1'b1;
                    ce_n_d      = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            // Address and data have been stable for one cycle before we_n falls
            S_WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = 4'd0;
                state_d = S_WR_PULSE;
            end

            S_WR_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    we_n_d  = 1'b1;
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            // One cycle of hold after we_n rises before releasing the bus
            S_WR_HOLD: begin
                ce_n_d    = 1'b1;
                data_oe_d = 1'b0;
                ready_d   = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready         = ready_q;
    assign data_read     = data_read_q;
    assign sram_addr     = sram_addr_q;
    assign sram_data_out = sram_data_out_q;
    assign sram_data_oe  = data_oe_q;
    assign sram_ce_n     = ce_n_q;
    assign sram_oe_n     = oe_n_q;
    assign sram_we_n     = we_n_q;
    assign sram_ub_n     = 1'b0;
    assign sram_lb_n     = 1'b0;
    assign state_dbg     = state_q;

endmodule
